// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared types and constants for the pipeline hazard/control unit.
// Rev     : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [0:0] {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
`default_nettype none
// ============================================================================
// Module  : perf_counter
// Brief   : Saturating event counter with synchronous clear (clear wins).
// Rev     : 1.0  initial release
// ============================================================================
module perf_counter #(
    parameter int P_CNT_WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_inc,
    output logic [P_CNT_WIDTH-1:0] o_cnt
);

    localparam logic [P_CNT_WIDTH-1:0] c_ONE = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [P_CNT_WIDTH-1:0] cnt_q;
    logic [P_CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + c_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Forwarding, load-use stall, branch flush, multi-cycle EX hold and
//           performance counters for the 5-stage RISC-V pipeline.
// Rev     : 2.0  adds multi-cycle execute FSM and perf counters
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int P_REG_ADDR_WIDTH = 5,
    parameter int P_LAT_WIDTH      = 6,
    parameter int P_CNT_WIDTH      = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [P_REG_ADDR_WIDTH-1:0] i_rs1_addr_d,
    input  logic [P_REG_ADDR_WIDTH-1:0] i_rs2_addr_d,
    input  logic [P_REG_ADDR_WIDTH-1:0] i_rs1_addr_e,
    input  logic [P_REG_ADDR_WIDTH-1:0] i_rs2_addr_e,
    input  logic [P_REG_ADDR_WIDTH-1:0] i_rd_addr_e,
    input  logic                        i_regwrite_e,
    input  logic [1:0]                  i_resultsrc_e,
    input  logic [P_REG_ADDR_WIDTH-1:0] i_rd_addr_m,
    input  logic                        i_regwrite_m,
    input  logic [P_REG_ADDR_WIDTH-1:0] i_rd_addr_w,
    input  logic                        i_regwrite_w,
    input  logic                        i_pcsrc_e,
    input  logic                        i_mc_start_e,
    input  logic [P_LAT_WIDTH-1:0]      i_mc_lat_e,
    input  logic                        i_retire_w,
    input  logic                        i_cnt_clear,
    output logic                        o_stall_f,
    output logic                        o_stall_d,
    output logic                        o_stall_e,
    output logic                        o_flush_d,
    output logic                        o_flush_e,
    output logic                        o_flush_m,
    output logic [1:0]                  o_forward_a_e,
    output logic [1:0]                  o_forward_b_e,
    output logic                        o_mc_busy,
    output logic                        o_protocol_err,
    output logic [P_CNT_WIDTH-1:0]      o_cnt_cycles,
    output logic [P_CNT_WIDTH-1:0]      o_cnt_stalls,
    output logic [P_CNT_WIDTH-1:0]      o_cnt_flushes,
    output logic [P_CNT_WIDTH-1:0]      o_cnt_retired
);

    localparam logic [P_LAT_WIDTH-1:0] c_LAT_ONE = {{(P_LAT_WIDTH-1){1'b0}}, 1'b1};

    mc_state_t              state_q, state_d;
    logic [P_LAT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   w_mc_hold;
    logic                   w_lduse;
    logic                   w_pc_accept;

    function automatic fwd_sel_t fwd_select(
        input logic [P_REG_ADDR_WIDTH-1:0] rs,
        input logic [P_REG_ADDR_WIDTH-1:0] rd_m,
        input logic                        we_m,
        input logic [P_REG_ADDR_WIDTH-1:0] rd_w,
        input logic                        we_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign o_forward_a_e = fwd_select(i_rs1_addr_e, i_rd_addr_m, i_regwrite_m,
                                      i_rd_addr_w, i_regwrite_w);
    assign o_forward_b_e = fwd_select(i_rs2_addr_e, i_rd_addr_m, i_regwrite_m,
                                      i_rd_addr_w, i_regwrite_w);

    assign w_lduse = (i_resultsrc_e == RESULTSRC_LOAD) && i_regwrite_e &&
                     (i_rd_addr_e != '0) &&
                     ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

    // cnt holds the EX cycles still owed after the current one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        w_mc_hold = 1'b0;
        case (state_q)
            MC_IDLE: begin
                if (i_mc_start_e && (i_mc_lat_e > c_LAT_ONE)) begin
                    w_mc_hold = 1'b1;
                    cnt_d     = i_mc_lat_e - c_LAT_ONE;
                    state_d   = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (i_pcsrc_e || i_mc_start_e) begin
                    err_d = 1'b1;
                end
                if (cnt_q > c_LAT_ONE) begin
                    w_mc_hold = 1'b1;
                    cnt_d     = cnt_q - c_LAT_ONE;
                end else begin
                    cnt_d   = '0;
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // A redirect arriving while BUSY is illegal and dropped.
    assign w_pc_accept = i_pcsrc_e && (state_q == MC_IDLE);

    always_comb begin
        o_stall_f = w_mc_hold || (w_lduse && !w_pc_accept);
        o_stall_d = w_mc_hold || (w_lduse && !w_pc_accept);
        o_stall_e = w_mc_hold;
        o_flush_d = w_pc_accept;
        o_flush_e = !w_mc_hold && (w_pc_accept || w_lduse);
        o_flush_m = w_mc_hold;
    end

    assign o_mc_busy      = (state_q == MC_BUSY);
    assign o_protocol_err = err_q;

    perf_counter #(.P_CNT_WIDTH(P_CNT_WIDTH)) u_cnt_cycles (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_cnt_clear),
        .i_inc(1'b1), .o_cnt(o_cnt_cycles)
    );

    perf_counter #(.P_CNT_WIDTH(P_CNT_WIDTH)) u_cnt_stalls (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_cnt_clear),
        .i_inc(o_stall_f), .o_cnt(o_cnt_stalls)
    );

    perf_counter #(.P_CNT_WIDTH(P_CNT_WIDTH)) u_cnt_flushes (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_cnt_clear),
        .i_inc(w_pc_accept), .o_cnt(o_cnt_flushes)
    );

    perf_counter #(.P_CNT_WIDTH(P_CNT_WIDTH)) u_cnt_retired (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_cnt_clear),
        .i_inc(i_retire_w), .o_cnt(o_cnt_retired)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed and random stimulus against a cycle-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LW  = 6;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          we_e, we_m, we_w, pcsrc, mc_start, retire, clr;
    logic [1:0]    rsrc;
    logic [LW-1:0] lat;

    logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic [1:0]    fwd_a, fwd_b;
    logic          busy, perr;
    logic [CW-1:0] c_cyc, c_stl, c_fls, c_ret;

    pipeline_hazard_ctrl #(
        .P_REG_ADDR_WIDTH(AW), .P_LAT_WIDTH(LW), .P_CNT_WIDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d),
        .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e), .i_rd_addr_e(rd_e),
        .i_regwrite_e(we_e), .i_resultsrc_e(rsrc),
        .i_rd_addr_m(rd_m), .i_regwrite_m(we_m),
        .i_rd_addr_w(rd_w), .i_regwrite_w(we_w),
        .i_pcsrc_e(pcsrc), .i_mc_start_e(mc_start), .i_mc_lat_e(lat),
        .i_retire_w(retire), .i_cnt_clear(clr),
        .o_stall_f(stall_f), .o_stall_d(stall_d), .o_stall_e(stall_e),
        .o_flush_d(flush_d), .o_flush_e(flush_e), .o_flush_m(flush_m),
        .o_forward_a_e(fwd_a), .o_forward_b_e(fwd_b),
        .o_mc_busy(busy), .o_protocol_err(perr),
        .o_cnt_cycles(c_cyc), .o_cnt_stalls(c_stl),
        .o_cnt_flushes(c_fls), .o_cnt_retired(c_ret)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: ex_left = EX cycles an in-flight op still owes after this one.
    int ex_left;
    bit m_err;
    int m_cyc, m_stl, m_fls, m_ret;
    bit e_busy, e_hold, e_pc_ok, e_lduse, e_sf, e_fe;
    int e_fa, e_fb;

    function automatic int fwd_model(input logic [AW-1:0] rs);
        if (we_m && rd_m != 0 && rd_m == rs) return 2;
        if (we_w && rd_w != 0 && rd_w == rs) return 1;
        return 0;
    endfunction

    function automatic int sat_inc(input int c, input bit inc);
        if (clr) return 0;
        if (inc && c < MAXC) return c + 1;
        return c;
    endfunction

    task automatic model_eval();
        e_fa    = fwd_model(rs1_e);
        e_fb    = fwd_model(rs2_e);
        e_busy  = ex_left > 0;
        e_hold  = e_busy ? (ex_left > 1) : (mc_start && lat > 1);
        e_pc_ok = pcsrc && !e_busy;
        e_lduse = rsrc == 2'b01 && we_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        e_sf    = e_hold || (e_lduse && !e_pc_ok);
        e_fe    = !e_hold && (e_pc_ok || e_lduse);
    endtask

    task automatic model_reset();
        ex_left = 0; m_err = 0;
        m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0;
    endtask

    task automatic compare_all();
        model_eval();
        check("fwd_a", fwd_a, e_fa);
        check("fwd_b", fwd_b, e_fb);
        check("stall_f", stall_f, e_sf);
        check("stall_d", stall_d, e_sf);
        check("stall_e", stall_e, e_hold);
        check("flush_d", flush_d, e_pc_ok);
        check("flush_e", flush_e, e_fe);
        check("flush_m", flush_m, e_hold);
        check("mc_busy", busy, e_busy);
        check("proto_err", perr, m_err);
        check("cnt_cycles", c_cyc, m_cyc);
        check("cnt_stalls", c_stl, m_stl);
        check("cnt_flushes", c_fls, m_fls);
        check("cnt_retired", c_ret, m_ret);
    endtask

    // Called just after a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        #1;
        compare_all();
        if (e_busy) ex_left--;
        else if (mc_start && lat > 1) ex_left = int'(lat) - 1;
        if (e_busy && (pcsrc || mc_start)) m_err = 1;
        m_cyc = sat_inc(m_cyc, 1'b1);
        m_stl = sat_inc(m_stl, e_sf);
        m_fls = sat_inc(m_fls, e_pc_ok);
        m_ret = sat_inc(m_ret, retire);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        we_e = 0; we_m = 0; we_w = 0; rsrc = 0; pcsrc = 0; mc_start = 0; lat = 0;
        retire = 0; clr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one multi-cycle op and counts how long the hold lasts.
    task automatic run_mc(input int l, input int exp_stalls, input int exp_busy);
        int n_st, n_busy, n_fe;
        n_st = 0; n_busy = 0; n_fe = 0;
        mc_start = 1; lat = LW'(l);
        for (int k = 0; k < l + 1; k++) begin
            #1;
            n_st   += int'(stall_e);
            n_busy += int'(busy);
            n_fe   += int'(flush_e);
            #0 step();
            mc_start = 0; lat = 0;
        end
        check("mc_stall_cycles", n_st, exp_stalls);
        check("mc_busy_cycles", n_busy, exp_busy);
        check("mc_flush_e", n_fe, 0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        do_reset();
        check("reset_stall_f", stall_f, 0);
        check("reset_cycles", c_cyc, 0);

        // Saturation of the cycle counter.
        for (int k = 0; k < 20; k++) step();
        check("cycles_sat", c_cyc, MAXC);

        // Forwarding priority.
        rd_m = 5; rd_w = 5; we_m = 1; we_w = 1; rs1_e = 5; rs2_e = 5;
        #1 check("fwd_mem", fwd_a, 2'b10);
        step();
        we_m = 0;
        #1 check("fwd_wb", fwd_b, 2'b01);
        step();
        rd_m = 0; rd_w = 0; we_m = 1;
        #1 check("fwd_rf", fwd_a, 2'b00);
        step();
        idle_inputs();

        // Load-use, then load-use masked by a taken branch.
        rsrc = 2'b01; we_e = 1; rd_e = 7; rs2_d = 7;
        #1 check("lduse_flush_e", flush_e, 1);
        step();
        idle_inputs();
        step();
        rsrc = 2'b01; we_e = 1; rd_e = 7; rs2_d = 7; pcsrc = 1;
        #1 check("lduse_pc_stall_f", stall_f, 0);
        step();
        idle_inputs();
        step();

        // Multi-cycle ops: lat=4, lat=1, back-to-back lat=3 then lat=2.
        run_mc(4, 3, 3);
        run_mc(1, 0, 0);
        mc_start = 1; lat = 3;
        step();
        mc_start = 0; lat = 0;
        step(); step();
        mc_start = 1; lat = 2;
        step();
        mc_start = 0; lat = 0;
        step();
        check("b2b_no_err", perr, 0);
        step();

        // Branch during BUSY is dropped and flagged.
        mc_start = 1; lat = 5;
        step();
        mc_start = 0; lat = 0; pcsrc = 1;
        #1 check("busy_pc_no_flush", flush_d, 0);
        step();
        pcsrc = 0;
        for (int k = 0; k < 4; k++) step();
        check("proto_err_set", perr, 1);

        // Async reset in the 2nd BUSY cycle of a lat=10 op.
        mc_start = 1; lat = 10;
        step();
        mc_start = 0; lat = 0;
        step();
        rst = 1'b1;
        #1;
        check("rst_mid_stall_f", stall_f, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_retired", c_ret, 0);
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic.
        for (int k = 0; k < 800; k++) begin
            rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3));
            rs1_e = AW'($urandom_range(0, 3)); rs2_e = AW'($urandom_range(0, 3));
            rd_e  = AW'($urandom_range(0, 3)); rd_m  = AW'($urandom_range(0, 3));
            rd_w  = AW'($urandom_range(0, 3));
            we_e = 1'($urandom); we_m = 1'($urandom); we_w = 1'($urandom);
            rsrc = 2'($urandom);
            pcsrc    = ($urandom_range(0, 7) == 0);
            mc_start = ($urandom_range(0, 5) == 0);
            lat      = LW'($urandom_range(0, 7));
            retire   = 1'($urandom);
            clr      = ($urandom_range(0, 19) == 0);
            step();
            if (k == 400) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
